audio_adc_rx: RTL

Serial audio capture block for the codec's ADC path. It is the receive-side counterpart of the DAC serializer already driving `audio_DACDAT`. The block samples the codec-mastered `audio_BCLK`/`audio_ADCLRCK`/`audio_ADCDAT` lines (I2S format) in the system clock domain and deserializes each left/right frame into one packed word. Each word is buffered in a small FIFO and presented on a valid/ready stream for the HPS-facing register/DMA logic.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/audio_sample_fifo.sv | 63 ++++++
 rtl/audio_adc_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared codec audio constants and capture FSM state encoding
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 16;
    localparam int AUDIO_FIFO_DEPTH   = 16;

    // I2S places the MSB one bit clock after the frame clock edge
    localparam int I2S_MSB_OFFSET = 1;

    typedef enum logic [2:0] {
        IDLE,
        SKIP_L,
        SHIFT_L,
        WAIT_L,
        SKIP_R,
        SHIFT_R,
        WAIT_R
    } rx_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous first-word-fall-through FIFO with registered head
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         in_tdata,
    input  logic                     in_tvalid,
    output logic [WIDTH-1:0]         out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] avail;
    logic             push;
    logic             pop;

    assign count   = wr_ptr - rd_ptr;
    assign level   = count;
    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = out_tvalid && out_tready;
    assign push    = in_tvalid && (!full || pop);
    assign rd_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign avail   = pop ? count - PTR_W'(1) : count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_tdata;
        end
    end

    // Head is reloaded from storage as it stood before this edge, so a fresh
    // write into an empty FIFO becomes visible one cycle after it lands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            out_tvalid <= (avail != '0);
            out_tdata  <= mem[rd_next[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/audio_adc_rx.sv
// rtl/audio_adc_rx.sv - I2S ADC capture: synchronise, deframe left/right pairs, buffer to stream
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = AUDIO_FIFO_DEPTH
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          enable,
    input  logic                          audio_BCLK,
    input  logic                          audio_ADCLRCK,
    input  logic                          audio_ADCDAT,
    output logic [2*SAMPLE_WIDTH-1:0]     sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_SKIP = CNT_W'(I2S_MSB_OFFSET - 1);

    logic [2:0]              bclk_sync;
    logic [2:0]              lrck_sync;
    logic [2:0]              dat_sync;
    logic                    bclk_rise;
    logic                    lrck_fall;
    logic                    lrck_rise;
    rx_state_t               state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] next_shift;
    logic [SAMPLE_WIDTH-1:0] left_word;
    logic [SAMPLE_WIDTH-1:0] right_word;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Data rides the same three-stage delay so each bit lines up with its strobe.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_rise <= 1'b0;
            lrck_fall <= 1'b0;
            lrck_rise <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], audio_BCLK};
            lrck_sync <= {lrck_sync[1:0], audio_ADCLRCK};
            dat_sync  <= {dat_sync[1:0], audio_ADCDAT};
            bclk_rise <= bclk_sync[1] & ~bclk_sync[2];
            lrck_fall <= ~lrck_sync[1] & lrck_sync[2];
            lrck_rise <= lrck_sync[1] & ~lrck_sync[2];
        end
    end

    assign next_shift = {shift_reg[SAMPLE_WIDTH-2:0], dat_sync[2]};

    // Frame-clock edges take priority: any unexpected edge abandons the pair in progress.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_word  <= '0;
            right_word <= '0;
        end else if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else if (lrck_fall) begin
            state   <= SKIP_L;
            bit_cnt <= '0;
        end else if (lrck_rise) begin
            state   <= (state == WAIT_L) ? SKIP_R : IDLE;
            bit_cnt <= '0;
        end else if (bclk_rise) begin
            case (state)
                SKIP_L, SKIP_R: begin
                    if (bit_cnt == LAST_SKIP) begin
                        state   <= (state == SKIP_L) ? SHIFT_L : SHIFT_R;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                SHIFT_L, SHIFT_R: begin
                    shift_reg <= next_shift;
                    if (bit_cnt == LAST_BIT) begin
                        if (state == SHIFT_L) begin
                            left_word <= next_shift;
                            state     <= WAIT_L;
                        end else begin
                            right_word <= next_shift;
                            state      <= WAIT_R;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign push = enable && (state == WAIT_R) && lrck_fall;
    assign pop  = sample_valid && sample_ready && !fifo_empty;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    audio_sample_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_clk),
        .resetn     (reset_reset_n),
        .in_tdata   ({left_word, right_word}),
        .in_tvalid  (push),
        .out_tdata  (sample_data),
        .out_tvalid (sample_valid),
        .out_tready (sample_ready),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule
